// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory port (MEM stage, arbiter, data_memory).
package dmem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_BYTE = 3'b000;
  localparam logic [MODE_W-1:0] MODE_HALF = 3'b001;
  localparam logic [MODE_W-1:0] MODE_WORD = 3'b010;

  typedef enum logic {
    S_SHARE = 1'b0,
    S_BURST = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic              we;
    logic [MODE_W-1:0] mode;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  // Value presented to the memory when nobody holds the port
  localparam mem_req_t MEM_REQ_IDLE = '{we: 1'b0, mode: MODE_WORD, addr: '0, wdata: '0};

endpackage

// File: rtl/dmem_req_mux.sv
// Routes the granted requester onto the memory port; idle defaults otherwise.
module dmem_req_mux
  import dmem_pkg::*;
(
  input  logic     core_gnt,
  input  logic     dma_gnt,
  input  mem_req_t core_req,
  input  mem_req_t dma_req,
  output mem_req_t mem_req
);

  // Grants are mutually exclusive; a denied store never reaches the memory
  always_comb begin
    mem_req = MEM_REQ_IDLE;
    if (core_gnt) begin
      mem_req = core_req;
    end else if (dma_gnt) begin
      mem_req = dma_req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: core priority, DMA starvation guard and bounded DMA bursts.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MAX_BURST    = 8,
  parameter int unsigned CNT_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [MODE_W-1:0] core_mode,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [MODE_W-1:0] dma_mode,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_last,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic              mem_we,
  output logic [MODE_W-1:0] mem_mode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0]  beat_cnt;
  logic              core_pri_q, core_pri_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              dma_rvalid_q, dma_rvalid_d;
  logic              core_gnt;
  mem_req_t          core_bus, dma_bus, mem_bus;

  // Grant decision from registered state and live requests; nothing granted in reset
  always_comb begin
    core_gnt = 1'b0;
    dma_gnt  = 1'b0;
    if (!rst) begin
      if (state_q == S_BURST) begin
        dma_gnt = dma_req;
      end else if (core_req && dma_req) begin
        if (!core_pri_q && (starve_cnt_q >= CNT_W'(STARVE_LIMIT))) begin
          dma_gnt = 1'b1;
        end else begin
          core_gnt = 1'b1;
        end
      end else begin
        core_gnt = core_req;
        dma_gnt  = dma_req;
      end
    end
  end

  assign core_stall = ~rst & core_req & ~core_gnt;
  assign core_rdata = mem_rdata;
  assign beat_cnt   = burst_cnt_q + CNT_W'(1);

  // Next-state: burst tracking, starvation counter and DMA read capture
  always_comb begin
    state_d      = state_q;
    burst_cnt_d  = burst_cnt_q;
    core_pri_d   = 1'b0;
    starve_cnt_d = starve_cnt_q;
    dma_rvalid_d = dma_gnt & ~dma_we;
    dma_rdata_d  = dma_rdata_q;

    if (dma_gnt || !dma_req) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q < CNT_W'(STARVE_LIMIT)) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end

    if (dma_gnt && !dma_we) begin
      dma_rdata_d = mem_rdata;
    end

    case (state_q)
      S_SHARE: begin
        if (dma_gnt && !dma_last) begin
          state_d     = S_BURST;
          burst_cnt_d = CNT_W'(1);
        end
      end
      S_BURST: begin
        if (dma_gnt) begin
          if (dma_last) begin
            state_d     = S_SHARE;
            burst_cnt_d = '0;
          end else if (beat_cnt >= CNT_W'(MAX_BURST)) begin
            // Forced release: hand the core one guaranteed cycle
            state_d     = S_SHARE;
            burst_cnt_d = '0;
            core_pri_d  = 1'b1;
          end else begin
            burst_cnt_d = beat_cnt;
          end
        end
      end
      default: state_d = S_SHARE;
    endcase
  end

  // State and response registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_SHARE;
      starve_cnt_q <= '0;
      burst_cnt_q  <= '0;
      core_pri_q   <= 1'b0;
      dma_rdata_q  <= '0;
      dma_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
      core_pri_q   <= core_pri_d;
      dma_rdata_q  <= dma_rdata_d;
      dma_rvalid_q <= dma_rvalid_d;
    end
  end

  assign dma_rdata  = dma_rdata_q;
  assign dma_rvalid = dma_rvalid_q;

  assign core_bus = '{we: core_we, mode: core_mode, addr: core_addr, wdata: core_wdata};
  assign dma_bus  = '{we: dma_we, mode: dma_mode, addr: dma_addr, wdata: dma_wdata};

  dmem_req_mux u_req_mux (
    .core_gnt (core_gnt),
    .dma_gnt  (dma_gnt),
    .core_req (core_bus),
    .dma_req  (dma_bus),
    .mem_req  (mem_bus)
  );

  assign mem_we    = mem_bus.we;
  assign mem_mode  = mem_bus.mode;
  assign mem_addr  = mem_bus.addr;
  assign mem_wdata = mem_bus.wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: per-cycle vector table plus DMA read scoreboard.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_req = 1'b0, core_we = 1'b0;
  logic [2:0]  core_mode = MODE_WORD;
  logic [31:0] core_addr = '0, core_wdata = '0;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        dma_req = 1'b0, dma_we = 1'b0, dma_last = 1'b0;
  logic [2:0]  dma_mode = MODE_WORD;
  logic [31:0] dma_addr = '0, dma_wdata = '0;
  logic        dma_gnt;
  logic [31:0] dma_rdata;
  logic        dma_rvalid;
  logic        mem_we;
  logic [2:0]  mem_mode;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_mode(core_mode),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_mode(dma_mode),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_last(dma_last),
    .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_we(mem_we), .mem_mode(mem_mode), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic int nbytes(logic [2:0] m);
    if (m == MODE_BYTE) return 1;
    if (m == MODE_HALF) return 2;
    return 4;
  endfunction

  // Behavioural data memory seen by the DUT (zero-extending loads, 64 bytes, wraps)
  logic [7:0] tb_mem  [64];
  logic [7:0] ref_mem [64];

  always_comb begin
    mem_rdata = '0;
    for (int b = 0; b < 4; b++)
      if (b < nbytes(mem_mode)) mem_rdata[8*b +: 8] = tb_mem[6'(mem_addr + 32'(b))];
  end

  always @(posedge clk)
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (b < nbytes(mem_mode)) tb_mem[6'(mem_addr + 32'(b))] <= mem_wdata[8*b +: 8];

  // Reference memory, updated only from the expected grants
  function automatic logic [31:0] ref_rd(logic [31:0] a, logic [2:0] m);
    logic [31:0] r = '0;
    for (int b = 0; b < 4; b++)
      if (b < nbytes(m)) r[8*b +: 8] = ref_mem[6'(a + 32'(b))];
    return r;
  endfunction

  task automatic ref_wr(logic [31:0] a, logic [2:0] m, logic [31:0] d);
    for (int b = 0; b < 4; b++)
      if (b < nbytes(m)) ref_mem[6'(a + 32'(b))] = d[8*b +: 8];
  endtask

  typedef struct {
    logic        rst;
    logic        creq, cwe;
    logic [2:0]  cmode;
    logic [31:0] caddr, cwdata;
    logic        dreq, dwe;
    logic [2:0]  dmode;
    logic [31:0] daddr, dwdata;
    logic        dlast;
    logic        xstall, xgnt;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] rq[$];
  int n_chk = 0;
  int n_fail = 0;
  int row = 0;

  function automatic vec_t mk(logic r, logic cr, logic cw, logic [2:0] cm, logic [31:0] ca,
                              logic [31:0] cd, logic dr, logic dw, logic [2:0] dm,
                              logic [31:0] da, logic [31:0] dd, logic dl, logic xs, logic xg);
    vec_t v;
    v = '{rst: r, creq: cr, cwe: cw, cmode: cm, caddr: ca, cwdata: cd, dreq: dr, dwe: dw,
          dmode: dm, daddr: da, dwdata: dd, dlast: dl, xstall: xs, xgnt: xg};
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  function automatic vec_t idle();
    return mk(0, 0, 0, MODE_WORD, 0, 0, 0, 0, MODE_WORD, 0, 0, 0, 0, 0);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic        eg_core, eg_dma;
    logic        x_we;
    logic [2:0]  x_mode;
    logic [31:0] x_addr, x_wdata, x_rdata;
    vec_t        v;

    for (int i = 0; i < 64; i++) begin
      tb_mem[i]  = 8'h00;
      ref_mem[i] = 8'h00;
    end
    x_rdata = '0;

    // Reset with both sides requesting: no grants, no stall, no write
    for (int k = 0; k < 2; k++)
      vecs.push_back(mk(1, 1, 1, MODE_WORD, 3, 32'h1111, 1, 1, MODE_WORD, 32'h10, 32'h2222, 0, 0, 0));
    // Core only: unaligned word store then load
    vecs.push_back(mk(0, 1, 1, MODE_WORD, 3, 32'h9926E3DC, 0, 0, MODE_WORD, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, MODE_WORD, 3, 0, 0, 0, MODE_WORD, 0, 0, 0, 0, 0));
    // Starvation: core wins 4 cycles, DMA read wins the 5th while a core store is held off
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(0, 1, 1, MODE_WORD, 8, 32'h55550000 | 32'(k), 1, 0, MODE_WORD, 3, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, MODE_WORD, 8, 32'hDEADBEEF, 1, 0, MODE_WORD, 3, 0, 1, 1, 1));
    vecs.push_back(mk(0, 1, 0, MODE_WORD, 8, 0, 1, 0, MODE_WORD, 3, 0, 1, 0, 0));
    vecs.push_back(idle());
    // 3-beat burst entered through starvation, core stalled throughout
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(0, 1, 0, MODE_WORD, 8, 0, 1, 1, MODE_WORD, 32'h20, 32'hB0, 0, 0, 0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0, 1, 0, MODE_WORD, 8, 0, 1, 1, MODE_WORD, 32'h20 + 32'(k),
                        32'hB1 + 32'(k), logic'(k == 2), 1, 1));
    vecs.push_back(mk(0, 1, 0, MODE_WORD, 8, 0, 1, 1, MODE_WORD, 32'h30, 32'hCC, 0, 0, 0));
    vecs.push_back(idle());
    // Burst without dma_last: bubble holds the burst, forced release after 8 beats
    vecs.push_back(mk(0, 0, 0, MODE_WORD, 0, 0, 1, 1, MODE_WORD, 32'h24, 32'hE0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, MODE_WORD, 12, 32'h77, 1, 1, MODE_WORD, 32'h25, 32'hE1, 0, 1, 1));
    vecs.push_back(mk(0, 1, 1, MODE_WORD, 12, 32'h77, 0, 0, MODE_WORD, 0, 0, 0, 1, 0));
    for (int k = 2; k < 8; k++)
      vecs.push_back(mk(0, 1, 0, MODE_WORD, 8, 0, 1, 1, MODE_WORD, 32'h24 + 32'(k),
                        32'hE0 + 32'(k), 0, 1, 1));
    vecs.push_back(mk(0, 1, 0, MODE_WORD, 8, 0, 1, 1, MODE_WORD, 32'h2C, 32'hEE, 0, 0, 0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0, 1, 0, MODE_WORD, 8, 0, 1, 0, MODE_WORD, 3, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, MODE_WORD, 8, 0, 1, 0, MODE_WORD, 3, 0, 1, 1, 1));
    vecs.push_back(idle());
    // Core byte store, then DMA byte read of the same location
    vecs.push_back(mk(0, 1, 1, MODE_BYTE, 1, 32'h0000002F, 0, 0, MODE_WORD, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, MODE_WORD, 0, 0, 1, 0, MODE_BYTE, 1, 0, 1, 0, 1));
    vecs.push_back(idle());
    // Reset in the second beat of a read burst
    vecs.push_back(mk(0, 0, 0, MODE_WORD, 0, 0, 1, 0, MODE_WORD, 3, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 1, MODE_WORD, 8, 32'hFFFF, 1, 0, MODE_WORD, 4, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, MODE_WORD, 8, 0, 1, 0, MODE_WORD, 4, 0, 0, 0, 0));
    vecs.push_back(idle());

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      row = i;
      @(negedge clk);
      rst = v.rst;
      core_req = v.creq; core_we = v.cwe; core_mode = v.cmode;
      core_addr = v.caddr; core_wdata = v.cwdata;
      dma_req = v.dreq; dma_we = v.dwe; dma_mode = v.dmode;
      dma_addr = v.daddr; dma_wdata = v.dwdata; dma_last = v.dlast;
      #1;

      // Registered DMA response against the scoreboard
      chk("dma_rvalid", 32'(dma_rvalid), 32'(rq.size() != 0));
      if (dma_rvalid) begin
        if (rq.size() != 0) x_rdata = rq.pop_front();
        else begin
          n_chk++; n_fail++;
          $display("FAIL dma_rvalid row %0d: got 1 with no read outstanding, required 0", row);
        end
      end else if (rq.size() != 0) begin
        void'(rq.pop_front());
      end
      chk("dma_rdata", dma_rdata, x_rdata);

      // Combinational grants and memory port
      eg_core = ~v.rst & v.creq & ~v.xstall;
      eg_dma  = v.xgnt;
      x_we = 1'b0; x_mode = MODE_WORD; x_addr = '0; x_wdata = '0;
      if (eg_core) begin
        x_we = v.cwe; x_mode = v.cmode; x_addr = v.caddr; x_wdata = v.cwdata;
      end else if (eg_dma) begin
        x_we = v.dwe; x_mode = v.dmode; x_addr = v.daddr; x_wdata = v.dwdata;
      end
      chk("core_stall", 32'(core_stall), 32'(v.xstall));
      chk("dma_gnt",    32'(dma_gnt),    32'(v.xgnt));
      chk("mem_we",     32'(mem_we),     32'(x_we));
      chk("mem_mode",   32'(mem_mode),   32'(x_mode));
      chk("mem_addr",   mem_addr,        x_addr);
      chk("mem_wdata",  mem_wdata,       x_wdata);
      if (eg_core && !v.cwe) chk("core_rdata", core_rdata, ref_rd(v.caddr, v.cmode));

      // Advance the reference across the coming clock edge
      if (v.rst) begin
        rq.delete();
        x_rdata = '0;
      end else begin
        if (eg_dma && !v.dwe) rq.push_back(ref_rd(v.daddr, v.dmode));
        if (eg_core && v.cwe) ref_wr(v.caddr, v.cmode, v.cwdata);
        if (eg_dma && v.dwe) ref_wr(v.daddr, v.dmode, v.dwdata);
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the pipeline MEM stage (core) and a DMA/debug loader (dma).
- Core has priority.
- DMA gets guaranteed service through a starvation counter, and may hold the port for bounded bursts.
- Sits between the MEM stage / DMA engine and data_memory, driving its write-enable, mode, address and write-data inputs.

Parameters:
- STARVE_LIMIT, 4, number of consecutive denied DMA cycles after which DMA beats a core request.
- MAX_BURST, 8, maximum consecutive DMA beats before forced release.
- CNT_W, 4, width of the starve and burst counters; must satisfy 2^CNT_W > max(STARVE_LIMIT, MAX_BURST).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- core_req  in  1  MEM stage performs a load or store this cycle
- core_we  in  1  core store
- core_mode  in  3  core access size: 000 byte, 001 half, 010 word
- core_addr  in  32  core byte address
- core_wdata  in  32  core store data
- core_rdata  out  32  load data, combinational passthrough of mem_rdata
- core_stall  out  1  core request not granted this cycle; pipeline must freeze
- dma_req  in  1  DMA beat pending
- dma_we  in  1  DMA write
- dma_mode  in  3  DMA access size
- dma_addr  in  32  DMA byte address
- dma_wdata  in  32  DMA write data
- dma_last  in  1  current beat is the last of a burst
- dma_gnt  out  1  DMA beat accepted this cycle
- dma_rdata  out  32  registered DMA read data
- dma_rvalid  out  1  dma_rdata valid, one-cycle pulse
- mem_we  out  1  to data memory
- mem_mode  out  3  to data memory
- mem_addr  out  32  to data memory
- mem_wdata  out  32  to data memory
- mem_rdata  in  32  from data memory (combinational read)

Behaviour:
- Clock is clk; reset is synchronous and active-high on rst.
- State register has two states:
  - S_SHARE: arbitrate every cycle.
  - S_BURST: DMA owns the port.
- Grant is combinational from the registered state plus current requests.
- S_SHARE arbitration:
  - Both requesting and starve_cnt < STARVE_LIMIT, and no core_pri: core wins.
  - Both requesting and starve_cnt == STARVE_LIMIT: DMA wins.
  - Only one requesting: that one wins.
  - core_pri flag set: core wins any conflict, overriding starve_cnt.
- S_BURST arbitration: DMA wins whenever dma_req=1; core_stall = core_req. A dma_req=0 bubble holds S_BURST; the core still stalls.
- Transitions:
  - S_SHARE -> S_BURST on a granted DMA beat with dma_last=0.
  - S_BURST -> S_SHARE on a granted beat with dma_last=1, or when burst_cnt reaches MAX_BURST.
  - burst_cnt counts granted beats, including the entry beat, and clears on exit.
  - On the forced exit (MAX_BURST), core_pri is set for exactly one cycle.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on cycles with dma_req=1 and dma_gnt=0.
  - Clears on dma_gnt or when dma_req=0.
- Memory mux:
  - Granted requester's we/mode/addr/wdata drive mem_*.
  - No grant: mem_we=0, mem_mode=010, mem_addr=0, mem_wdata=0.
  - A stalled core store must never reach mem_we.
- core_stall = core_req & ~core_granted (combinational). core_rdata = mem_rdata always; valid only when the core is granted.
- DMA reads: on a granted beat with dma_we=0, mem_rdata is captured into dma_rdata and dma_rvalid=1 in the next cycle. dma_rdata holds its value until the next DMA read.
- DMA writes complete in the grant cycle; there is no rvalid.
- Reset (rst=1 at a clk edge):
  - State goes to S_SHARE; starve_cnt, burst_cnt and core_pri go to 0.
  - dma_rvalid=0 and dma_rdata=0.
  - Applies mid-burst: the burst is abandoned and no rvalid is emitted for the in-flight beat.
  - While rst=1, all grants are forced to 0: core_stall=0, dma_gnt=0, mem_we=0.
- Latency: core 0 cycles when granted; DMA read data 1 cycle after grant.

Decomposition:
- Package dmem_pkg:
  - Mode constants MODE_BYTE=3'b000, MODE_HALF=3'b001, MODE_WORD=3'b010.
  - Arbiter state enum {S_SHARE, S_BURST}.
  - Shared with the MEM stage and data_memory.
- One natural sub-module: dmem_req_mux, the combinational select of the granted request onto mem_* with the idle defaults.
- Arbitration FSM, counters and the DMA response register stay in dmem_arbiter.

Test Plan:
- Core only: store word 0x9926E3DC at addr 3, then load from addr 3 -> core_stall=0 both cycles, mem_we=1 only in the store cycle, core_rdata=0x9926E3DC.
- Conflict with starvation, core_req and dma_req both held high continuously -> core granted 4 cycles, then dma_gnt=1 in cycle 5; starve_cnt returns to 0; a stalled core store produces no mem_we.
- DMA burst of 3 beats (dma_last on beat 3) while core requests -> dma_gnt for 3 consecutive cycles, core_stall=1 for those 3 cycles, back to S_SHARE and core granted in cycle 4.
- Burst with dma_last never asserted -> forced release after 8 beats, core granted on the next cycle via core_pri, DMA regains the port afterwards.
- DMA byte read at addr 1 after a core store byte of 0x2F -> dma_rvalid pulses 1 cycle after dma_gnt with dma_rdata matching the data_memory load-byte result.
- rst asserted in the 2nd beat of a burst -> next cycle state S_SHARE, dma_rvalid=0, dma_rdata=0; mem_we=0 and no grants while rst=1.
